// File: rtl/exu_seq.sv
// exu_seq - single-issue execution-unit sequencer.
//
// Accepts one decoded op, issues it to one of NUM_FU variable-latency
// functional units over a valid/ready request channel, waits for that unit's
// response and presents the result in a back-pressurable output register,
// together with the op latency in cycles and a timeout error flag. Exactly one
// op is in flight at a time; a flush cancels it at any point.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               cancel the in-flight op (wins over accept and retire)
//   in_valid/in_ready   issue handshake; in_fu/in_tag/in_a/in_b op fields
//   fu_req_valid        one-hot request to the selected unit
//   fu_req_ready        per-unit request accept
//   fu_req_a/fu_req_b   latched operands, broadcast to every unit
//   fu_resp_valid/fu_resp_data/fu_resp_redirect  per-unit response
//   out_valid/out_ready result handshake
//   out_data/out_redirect/out_tag/out_err/out_cycles  registered result
module exu_seq #(
  parameter int XLEN    = 64,
  parameter int NUM_FU  = 4,
  parameter int TAG_W   = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64,
  parameter int FU_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FU_W-1:0]        in_fu,
  input  logic [TAG_W-1:0]       in_tag,
  input  logic [XLEN-1:0]        in_a,
  input  logic [XLEN-1:0]        in_b,
  output logic [NUM_FU-1:0]      fu_req_valid,
  input  logic [NUM_FU-1:0]      fu_req_ready,
  output logic [XLEN-1:0]        fu_req_a,
  output logic [XLEN-1:0]        fu_req_b,
  input  logic [NUM_FU-1:0]      fu_resp_valid,
  input  logic [NUM_FU*XLEN-1:0] fu_resp_data,
  input  logic [NUM_FU-1:0]      fu_resp_redirect,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_data,
  output logic                   out_redirect,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_err,
  output logic [CNT_W-1:0]       out_cycles
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // The timeout can only fire if the saturating counter can actually reach
  // TIMEOUT-1; otherwise it is effectively disabled.
  localparam bit TO_EN = (TIMEOUT > 0) &&
                         ((longint'(TIMEOUT) - 1) <= longint'(CNT_MAX));
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT - 1);
  // Reported latency of a timed-out op, saturated to the counter width.
  localparam logic [CNT_W-1:0] TO_CYC =
      (longint'(TIMEOUT) >= longint'(CNT_MAX)) ? CNT_MAX : CNT_W'(TIMEOUT);

  logic [2:0]       state_reg, state_next;
  logic [FU_W-1:0]  fu_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [XLEN-1:0]  a_reg, b_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_inc;

  logic [XLEN-1:0]  resp_data_arr [NUM_FU];
  logic             sel_req_ready, sel_resp_valid, sel_redirect;
  logic [XLEN-1:0]  sel_data;
  logic             timeout_hit, accept;
  logic             load_in, load_ok, load_to;

  // Per-unit request decode and response unpacking.
  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
    assign fu_req_valid[gi]  = (state_reg == S_REQ) && (fu_reg == FU_W'(gi));
    assign resp_data_arr[gi] = fu_resp_data[gi*XLEN +: XLEN];
  end

  assign sel_req_ready  = fu_req_ready[fu_reg];
  assign sel_resp_valid = fu_resp_valid[fu_reg];
  assign sel_redirect   = fu_resp_redirect[fu_reg];
  assign sel_data       = resp_data_arr[fu_reg];

  assign fu_req_a = a_reg;
  assign fu_req_b = b_reg;

  assign cnt_inc     = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
  assign timeout_hit = TO_EN && (cnt_reg == TO_CNT);

  // in_ready is held low through reset so nothing is taken before IDLE is
  // established; in DONE a new op is taken only in the cycle the result retires.
  assign in_ready  = !rst && !flush &&
                     ((state_reg == S_IDLE) || ((state_reg == S_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_reg == S_DONE);

  always_comb begin
    state_next = state_reg;
    load_in    = 1'b0;
    load_ok    = 1'b0;
    load_to    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          load_in    = 1'b1;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        // A request accepted in the flush cycle will still produce a response,
        // which DRAIN has to absorb.
        if (flush)              state_next = sel_req_ready ? S_DRAIN : S_IDLE;
        else if (sel_req_ready) state_next = S_WAIT;
        else if (timeout_hit) begin
          load_to    = 1'b1;
          state_next = S_DONE;
        end
      end
      S_WAIT: begin
        if (flush)               state_next = sel_resp_valid ? S_IDLE : S_DRAIN;
        else if (sel_resp_valid) begin
          load_ok    = 1'b1;
          state_next = S_DONE;
        end else if (timeout_hit) begin
          load_to    = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (flush) state_next = S_IDLE;
        else if (out_ready) begin
          if (accept) begin
            load_in    = 1'b1;
            state_next = S_REQ;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (sel_resp_valid || timeout_hit) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      fu_reg       <= '0;
      tag_reg      <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      cnt_reg      <= '0;
      out_data     <= '0;
      out_redirect <= 1'b0;
      out_tag      <= '0;
      out_err      <= 1'b0;
      out_cycles   <= '0;
    end else begin
      state_reg <= state_next;

      if (load_in) begin
        fu_reg  <= in_fu;
        tag_reg <= in_tag;
        a_reg   <= in_a;
        b_reg   <= in_b;
      end

      // The counter keeps running in DRAIN so a unit that never answers
      // still lets the sequencer return to IDLE.
      if (load_in)
        cnt_reg <= '0;
      else if ((state_reg == S_REQ) || (state_reg == S_WAIT) || (state_reg == S_DRAIN))
        cnt_reg <= cnt_inc;

      if (load_ok) begin
        out_data     <= sel_data;
        out_redirect <= sel_redirect;
        out_tag      <= tag_reg;
        out_err      <= 1'b0;
        out_cycles   <= cnt_inc;
      end else if (load_to) begin
        out_data     <= '0;
        out_redirect <= 1'b0;
        out_tag      <= tag_reg;
        out_err      <= 1'b1;
        out_cycles   <= TO_CYC;
      end
    end
  end

endmodule

// File: tb/tb_exu_seq.sv
// tb_exu_seq - self-checking bench for exu_seq (TIMEOUT=8, four units).
// Directed steps followed by randomized ops; expected results come from a
// reference model that reasons about the cycle a unit accepts and responds.
module tb_exu_seq;

  localparam int XLEN = 64;
  localparam int NFU  = 4;
  localparam int TO   = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  flush = 1'b0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [1:0]            in_fu = '0;
  logic [3:0]            in_tag = '0;
  logic [XLEN-1:0]       in_a = '0, in_b = '0;
  logic [NFU-1:0]        fu_req_valid;
  logic [NFU-1:0]        fu_req_ready = '0;
  logic [XLEN-1:0]       fu_req_a, fu_req_b;
  logic [NFU-1:0]        fu_resp_valid = '0;
  logic [NFU*XLEN-1:0]   fu_resp_data = '0;
  logic [NFU-1:0]        fu_resp_redirect = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [XLEN-1:0]       out_data;
  logic                  out_redirect;
  logic [3:0]            out_tag;
  logic                  out_err;
  logic [7:0]            out_cycles;

  int checks = 0;
  int failures = 0;

  exu_seq #(.XLEN(XLEN), .NUM_FU(NFU), .TAG_W(4), .CNT_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_fu(in_fu), .in_tag(in_tag),
    .in_a(in_a), .in_b(in_b),
    .fu_req_valid(fu_req_valid), .fu_req_ready(fu_req_ready),
    .fu_req_a(fu_req_a), .fu_req_b(fu_req_b),
    .fu_resp_valid(fu_resp_valid), .fu_resp_data(fu_resp_data),
    .fu_resp_redirect(fu_resp_redirect),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_redirect(out_redirect), .out_tag(out_tag), .out_err(out_err),
    .out_cycles(out_cycles)
  );

  always #5 clk = ~clk;

  // One op: k = REQ/WAIT cycle index at which the unit accepts (>=TO: never),
  // d = extra cycles after acceptance before the response.
  typedef struct {
    int              fu;
    logic [3:0]      tag;
    logic [XLEN-1:0] a, b, resp;
    bit              redir;
    int              k, d, hold;
  } op_t;

  task automatic chk(input string name, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fu();
    fu_req_ready = '0;
    fu_resp_valid = '0;
    fu_resp_redirect = '0;
  endtask

  task automatic accept_op(input int fu, input logic [3:0] tag, input logic [XLEN-1:0] a, b);
    in_valid = 1'b1; in_fu = 2'(fu); in_tag = tag; in_a = a; in_b = b;
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.fu    = int'($urandom_range(0, NFU-1));
    o.tag   = 4'($urandom);
    o.a     = {$urandom, $urandom};
    o.b     = {$urandom, $urandom};
    o.resp  = {$urandom, $urandom};
    o.redir = 1'($urandom);
    o.k     = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 3));
    o.d     = int'($urandom_range(0, 5));
    o.hold  = int'($urandom_range(0, 2));
    return o;
  endfunction

  // Drives one op from IDLE (or from REQ if pre=1) through retirement.
  task automatic run_op(input op_t op, input bit pre, input bit chain, input op_t nxt);
    int j, last;
    logic [NFU-1:0]  exp_req;
    logic [XLEN-1:0] exp_data;
    logic            exp_red, exp_err;
    logic [7:0]      exp_cyc;
    j    = (op.k >= TO) ? 1000 : op.k + 1 + op.d;
    last = (j < TO) ? j : TO - 1;
    if (!pre) begin
      accept_op(op.fu, op.tag, op.a, op.b);
      @(negedge clk);
      chk("in_ready_idle", XLEN'(in_ready), 1);
      tick();
      in_valid = 1'b0;
    end
    for (int idx = 0; idx <= last; idx++) begin
      clear_fu();
      // Other units chatter; the sequencer must ignore them.
      for (int u = 0; u < NFU; u++) begin
        if (u != op.fu) begin
          fu_req_ready[u]     = 1'($urandom);
          fu_resp_valid[u]    = 1'($urandom);
          fu_resp_redirect[u] = 1'($urandom);
          fu_resp_data[u*XLEN +: XLEN] = {$urandom, $urandom};
        end
      end
      fu_req_ready[op.fu]  = (idx == op.k);
      fu_resp_valid[op.fu] = (idx == j);
      fu_resp_redirect[op.fu] = op.redir;
      fu_resp_data[op.fu*XLEN +: XLEN] = op.resp;
      @(negedge clk);
      exp_req = (idx <= op.k) ? (NFU'(1) << op.fu) : '0;
      chk("fu_req_valid", XLEN'(fu_req_valid), XLEN'(exp_req));
      if (idx == 0) begin
        chk("fu_req_a", fu_req_a, op.a);
        chk("fu_req_b", fu_req_b, op.b);
      end
      chk("busy_in_ready", XLEN'(in_ready), 0);
      chk("busy_out_valid", XLEN'(out_valid), 0);
      tick();
    end
    clear_fu();
    if (j < TO) begin
      exp_data = op.resp; exp_red = op.redir; exp_err = 1'b0; exp_cyc = 8'(j + 1);
    end else begin
      exp_data = '0; exp_red = 1'b0; exp_err = 1'b1; exp_cyc = 8'(TO);
    end
    for (int h = 0; h <= op.hold; h++) begin
      out_ready = (h == op.hold);
      if (h == op.hold && chain) accept_op(nxt.fu, nxt.tag, nxt.a, nxt.b);
      @(negedge clk);
      chk("out_valid", XLEN'(out_valid), 1);
      chk("out_data", out_data, exp_data);
      chk("out_tag", XLEN'(out_tag), XLEN'(op.tag));
      chk("out_err", XLEN'(out_err), XLEN'(exp_err));
      chk("out_redirect", XLEN'(out_redirect), XLEN'(exp_red));
      chk("out_cycles", XLEN'(out_cycles), XLEN'(exp_cyc));
      chk("done_in_ready", XLEN'(in_ready), XLEN'(h == op.hold));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    op_t cur, nxt, dummy;
    bit pre, chain;
    dummy = rand_op();

    // Reset state.
    tick(); tick();
    @(negedge clk);
    chk("rst_in_ready", XLEN'(in_ready), 0);
    chk("rst_out_valid", XLEN'(out_valid), 0);
    chk("rst_fu_req_valid", XLEN'(fu_req_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_cycles", XLEN'(out_cycles), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", XLEN'(in_ready), 1);
    tick();

    // Timeout: unit 3 never accepts; then timeout after acceptance in WAIT.
    cur = '{fu:3, tag:4'h9, a:64'h11, b:64'h22, resp:64'h33, redir:1'b1, k:99, d:0, hold:0};
    run_op(cur, 0, 0, dummy);
    cur = '{fu:1, tag:4'h3, a:64'h44, b:64'h55, resp:64'h66, redir:1'b1, k:2, d:9, hold:1};
    run_op(cur, 0, 0, dummy);

    // Minimum latency, back-pressure for 4 cycles, then retire+accept chain.
    cur = '{fu:2, tag:4'h5, a:64'hA, b:64'hB, resp:64'hDEAD, redir:1'b0, k:0, d:0, hold:4};
    nxt = '{fu:0, tag:4'hC, a:64'h1234, b:64'h5678, resp:64'hBEEF, redir:1'b1, k:1, d:2, hold:0};
    run_op(cur, 0, 1, nxt);
    run_op(nxt, 1, 0, dummy);

    // Reset in WAIT.
    accept_op(2, 4'h7, 64'h1, 64'h2); tick(); in_valid = 1'b0;
    fu_req_ready[2] = 1'b1; tick(); clear_fu();
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_in_ready", XLEN'(in_ready), 0);
    tick();
    @(negedge clk);
    chk("rstw_out_valid", XLEN'(out_valid), 0);
    chk("rstw_fu_req_valid", XLEN'(fu_req_valid), 0);
    chk("rstw_out_data", out_data, 0);
    chk("rstw_out_tag", XLEN'(out_tag), 0);
    chk("rstw_out_err", XLEN'(out_err), 0);
    chk("rstw_out_cycles", XLEN'(out_cycles), 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_in_ready_rel", XLEN'(in_ready), 1);
    tick();

    // Flush in WAIT: DRAIN, response at cycle 6 is swallowed, IDLE at 7.
    accept_op(1, 4'h1, 64'h10, 64'h20); tick(); in_valid = 1'b0;
    fu_req_ready[1] = 1'b1; tick(); clear_fu();
    flush = 1'b1;
    @(negedge clk);
    chk("fw_in_ready_flush", XLEN'(in_ready), 0);
    tick(); flush = 1'b0;
    for (int c = 3; c <= 6; c++) begin
      fu_resp_valid[1] = (c == 6);
      fu_resp_data[1*XLEN +: XLEN] = 64'hBAD;
      @(negedge clk);
      chk("fw_drain_in_ready", XLEN'(in_ready), 0);
      chk("fw_drain_req", XLEN'(fu_req_valid), 0);
      chk("fw_drain_out_valid", XLEN'(out_valid), 0);
      tick();
    end
    clear_fu();
    @(negedge clk);
    chk("fw_idle_in_ready", XLEN'(in_ready), 1);
    chk("fw_idle_out_valid", XLEN'(out_valid), 0);
    tick();

    // Flush coincident with request accept: DRAIN until the response.
    accept_op(0, 4'h2, 64'h30, 64'h40); tick(); in_valid = 1'b0;
    fu_req_ready[0] = 1'b1; flush = 1'b1; tick(); clear_fu(); flush = 1'b0;
    @(negedge clk);
    chk("fr_drain_in_ready", XLEN'(in_ready), 0);
    chk("fr_drain_req", XLEN'(fu_req_valid), 0);
    tick();
    fu_resp_valid[0] = 1'b1; tick(); clear_fu();
    @(negedge clk);
    chk("fr_idle_in_ready", XLEN'(in_ready), 1);
    chk("fr_idle_out_valid", XLEN'(out_valid), 0);
    tick();

    // Flush in REQ without accept: request withdrawn, back to IDLE.
    accept_op(3, 4'h4, 64'h50, 64'h60); tick(); in_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    chk("fq_req_valid", XLEN'(fu_req_valid), 4'b1000);
    tick(); flush = 1'b0;
    @(negedge clk);
    chk("fq_req_dropped", XLEN'(fu_req_valid), 0);
    chk("fq_in_ready", XLEN'(in_ready), 1);
    tick();

    // Flush in DONE drops out_valid.
    accept_op(2, 4'h6, 64'h70, 64'h80); tick(); in_valid = 1'b0;
    fu_req_ready[2] = 1'b1; tick(); clear_fu();
    fu_resp_valid[2] = 1'b1; tick(); clear_fu();
    out_ready = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk("fd_out_valid", XLEN'(out_valid), 1);
    chk("fd_in_ready", XLEN'(in_ready), 0);
    tick(); flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("fd_dropped", XLEN'(out_valid), 0);
    chk("fd_idle_in_ready", XLEN'(in_ready), 1);
    tick();

    // Randomized ops, some back-to-back.
    pre = 1'b0;
    cur = rand_op();
    for (int i = 0; i < 30; i++) begin
      nxt   = rand_op();
      chain = ($urandom_range(0, 2) == 0);
      run_op(cur, pre, chain, nxt);
      pre = chain;
      cur = nxt;
    end
    if (pre) run_op(cur, 1, 0, dummy);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
